ifetch_queue: RTL and testbench
===============================

Name: ifetch_queue

Overview:
- Parametrised instruction-fetch front end for the pipelined core. It replaces the single-entry IF/ID latch with a DEPTH-entry prefetch queue.
- Generates the fetch PC and drives the combinational instruction memory. It pre-decodes J/JAL so the jump is taken during fetch.
- Accepts a flushing redirect from EX (branch, JR) and hands {inst, pc+4} to decode over a valid/ready handshake.

Parameters:
- DEPTH, 4, queue entries; power of two, >= 2
- RESET_PC, 32'h0000_3000, first fetch address after reset
- IM_AW, 10, word-address width driven to instruction memory

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- im_addr  out  IM_AW  word address = fetch_pc[IM_AW+1:2]
- im_dout  in  32  instruction at im_addr, same cycle (combinational memory)
- redirect_valid  in  1  EX resolved a taken branch/JR; flush and refetch
- redirect_pc  in  32  target for redirect
- out_valid  out  1  head entry valid
- out_ready  in  1  decode accepts head this cycle
- out_inst  out  32  head instruction
- out_pc4  out  32  head instruction address + 4
- out_pred_taken  out  1  head was predicted taken (see Optional Feature)
- count  out  log2(DEPTH)+1  occupied entries

Behaviour:
- Reset (async, immediate): fetch_pc=RESET_PC, rd_ptr=wr_ptr=0, count=0, out_valid=0, out_inst=0, out_pc4=0, out_pred_taken=0.
- State: fetch_pc register; circular buffer of {inst, pc4, pred}; rd_ptr and wr_ptr wrap modulo DEPTH; count register.
- Outputs are driven from the head entry. out_valid = (count!=0). There is no bypass: an instruction appears at the output one cycle after it is fetched, at the earliest.
- pop = out_valid & out_ready.
- push = fetch_en & !redirect_valid, where fetch_en = (count<DEPTH) | pop. A full queue may fetch in the same cycle it pops.
- On push at a clock edge:
  - entry[wr_ptr] <= {im_dout, fetch_pc+4, pred}
  - wr_ptr advances
  - fetch_pc <= next_pc
- next_pc selection:
  - J/JAL (op 000010/000011): {pc4[31:28], im_dout[25:0], 2'b00}
  - predicted branch: the prediction target (see Optional Feature)
  - otherwise: fetch_pc+4
- JAL is still enqueued so the pipeline writes $31.
- With no push, fetch_pc holds. count updates as count + push - pop.
- Redirect has highest priority. At the edge it:
  - clears count, rd_ptr and wr_ptr
  - sets fetch_pc <= redirect_pc
  - ignores push and pop that cycle; a concurrent pop is discarded and decode must treat it as killed
- out_valid is 0 in the cycle after a redirect. The first instruction from the target is available one cycle later.
- Full with out_ready=0: fetch stalls, fetch_pc holds, im_addr stable.
- Empty with out_ready=1: no pop, and count does not underflow.
- PC arithmetic is modulo 2^32. fetch_pc[1:0] is always 00; redirect_pc[1:0] is forced to 00.
- Reset mid-operation discards all entries immediately.

Optional Feature:
- Macro: IFQ_BTFN_EN.
- Defined: static backward-taken/forward-not-taken prediction.
  - Applies to BEQ/BNE (op 000100/000101) fetched with imm[15]=1.
  - The instruction is predicted taken, and next_pc = fetch_pc+4+{sext(imm),2'b00}.
  - The queue entry's pred bit is set, so EX redirects to pc4 on a mispredict.
- Undefined: the pred logic is removed, out_pred_taken is tied to 0, and branches fetch sequentially.

Decomposition:
- Shared package (declarations header): opcode constants OP_J, OP_JAL, OP_BEQ, OP_BNE; instruction field ranges (Iop, Iaddr, Iimm); RESET_PC default.
- One sub-module: ifq_predecode. It is combinational: inputs inst and fetch_pc; outputs is_jump, is_pred_br, target. It keeps decode logic out of the queue control.

Test Plan:
1. Reset release, out_ready=1, sequential code at 0x3000: out_pc4 = 0x3004, 0x3008, 0x300C on consecutive cycles; out_valid first high one cycle after the first fetch edge.
2. out_ready=0 for 8 cycles, DEPTH=4: count reaches 4 and holds; im_addr is frozen at word (0x3010>>2). Raise out_ready: 4 pops in order, and fetch resumes at 0x3010 with no gap.
3. J 0x0C01 (im_dout=32'h08000C01) at 0x3000: the next fetch is 0x0000_3004; the J entry is still enqueued; no redirect needed.
4. Queue holds 3 entries; redirect_valid with redirect_pc=0x3040 while out_ready=1: the next cycle has count=0 and out_valid=0; the following cycle has out_pc4=0x3044.
5. Full queue, pop and push in the same cycle: count stays at 4; FIFO order is preserved across pointer wrap over 10+ cycles.
6. With IFQ_BTFN_EN, BNE with imm=16'hFFFC at 0x3010: next fetch is 0x3004, out_pred_taken=1 for that entry. Without the macro: next fetch is 0x3014, out_pred_taken=0.

Source files
------------

// File: rtl/ifetch_queue_pkg.sv
// Shared declarations for the instruction-fetch queue: opcodes, field ranges,
// default reset PC and the queue entry layout.
package ifetch_queue_pkg;

  localparam logic [31:0] IFQ_RESET_PC = 32'h0000_3000;

  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;

  localparam int IOP_HI   = 31;
  localparam int IOP_LO   = 26;
  localparam int IADDR_HI = 25;
  localparam int IADDR_LO = 0;
  localparam int IIMM_HI  = 15;
  localparam int IIMM_LO  = 0;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc4;
    logic        pred;
  } ifq_entry_t;

endpackage

// File: rtl/ifetch_queue_predecode.sv
// Combinational pre-decode of the fetched word: J/JAL detection and, when
// IFQ_BTFN_EN is defined, backward-branch prediction with its target.
module ifq_predecode
  import ifetch_queue_pkg::*;
(
  input  logic [31:0] inst,
  input  logic [31:0] fetch_pc,
  output logic        is_jump,
  output logic        is_pred_br,
  output logic [31:0] target
);

  logic [5:0]  op;
  logic [31:0] pc4;
  logic [31:0] jmp_tgt;
  logic [31:0] br_tgt;

  assign op      = inst[IOP_HI:IOP_LO];
  assign pc4     = fetch_pc + 32'd4;
  assign is_jump = (op == OP_J) || (op == OP_JAL);
  assign jmp_tgt = {pc4[31:28], inst[IADDR_HI:IADDR_LO], 2'b00};

`ifdef IFQ_BTFN_EN
  // Negative displacement means a backward branch, assumed to be a loop.
  assign is_pred_br = ((op == OP_BEQ) || (op == OP_BNE)) && inst[IIMM_HI];
  assign br_tgt     = pc4 + {{14{inst[IIMM_HI]}}, inst[IIMM_HI:IIMM_LO], 2'b00};
`else
  assign is_pred_br = 1'b0;
  assign br_tgt     = pc4;
`endif

  assign target = is_jump ? jmp_tgt : br_tgt;

endmodule

// File: rtl/ifetch_queue.sv
// DEPTH-entry prefetch queue between instruction memory and decode, with
// fetch-stage J/JAL redirection and optional BTFN prediction (IFQ_BTFN_EN).
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = IFQ_RESET_PC,
  parameter int          IM_AW    = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [IM_AW-1:0]       im_addr,
  input  logic [31:0]            im_dout,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_inst,
  output logic [31:0]            out_pc4,
  output logic                   out_pred_taken,
  output logic [$clog2(DEPTH):0] count
);

  localparam int            PW       = $clog2(DEPTH);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0]   count_q, count_d;
  ifq_entry_t    mem_q [DEPTH];
  ifq_entry_t    head;

  logic        is_jump, is_pred_br;
  logic [31:0] target, seq_pc, next_pc;
  logic        pop, fetch_en, push;

  ifq_predecode u_predecode (
    .inst       (im_dout),
    .fetch_pc   (fetch_pc_q),
    .is_jump    (is_jump),
    .is_pred_br (is_pred_br),
    .target     (target)
  );

  assign seq_pc   = fetch_pc_q + 32'd4;
  assign next_pc  = (is_jump || is_pred_br) ? target : seq_pc;

  // A full queue may still fetch when its head leaves in the same cycle.
  assign pop      = (count_q != '0) & out_ready;
  assign fetch_en = (count_q != FULL_CNT) | pop;
  assign push     = fetch_en & ~redirect_valid;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      if (push) begin
        wr_ptr_d   = wr_ptr_q + PW'(1);
        fetch_pc_d = next_pc;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + (PW+1)'(1);
        2'b01:   count_d = count_q - (PW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage is not reset; outputs are gated by out_valid instead.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{inst: im_dout, pc4: seq_pc, pred: is_pred_br};
  end

  assign head      = mem_q[rd_ptr_q];
  assign out_valid = (count_q != '0);
  assign out_inst  = out_valid ? head.inst : '0;
  assign out_pc4   = out_valid ? head.pc4  : '0;
  assign count     = count_q;
  assign im_addr   = fetch_pc_q[IM_AW+1:2];

`ifdef IFQ_BTFN_EN
  assign out_pred_taken = out_valid & head.pred;
  logic unused_ok;
  assign unused_ok = ^redirect_pc[1:0];
`else
  assign out_pred_taken = 1'b0;
  logic unused_ok;
  assign unused_ok = ^{redirect_pc[1:0], head.pred};
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Randomized bench for ifetch_queue against a queue-based behavioural model,
// plus directed scenarios with literal expectations. Honours IFQ_BTFN_EN.
module tb_ifetch_queue;

  localparam int DEPTH = 4;
`ifdef IFQ_BTFN_EN
  localparam bit BTFN = 1'b1;
`else
  localparam bit BTFN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  im_addr;
  logic [31:0] im_dout;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst, out_pc4;
  logic        out_pred_taken;
  logic [2:0]  count;

  logic [31:0] imem [1024];
  assign im_dout = imem[im_addr];

  always #5 clk = ~clk;

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_3000), .IM_AW(10)) dut (
    .clk(clk), .rst(rst), .im_addr(im_addr), .im_dout(im_dout),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_pc4(out_pc4), .out_pred_taken(out_pred_taken), .count(count)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a plain queue of fetched words and a fetch address.
  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc4;
    bit          pred;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] mpc = 32'h0000_3000;
  bit          model_on = 1'b0;

  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] inst,
                                             output bit pred);
    logic [5:0]  op  = inst[31:26];
    logic [31:0] seq = pc + 32'd4;
    pred = BTFN && (op == 6'd4 || op == 6'd5) && inst[15];
    if (op == 6'd2 || op == 6'd3) return {seq[31:28], inst[25:0], 2'b00};
    if (pred) return seq + ({{16{inst[15]}}, inst[15:0]} << 2);
    return seq;
  endfunction

  always @(posedge clk or posedge rst) begin
    bit   m_pop, m_push, m_pred;
    ent_t e;
    if (rst) begin
      mq.delete();
      mpc = 32'h0000_3000;
    end else if (redirect_valid) begin
      mq.delete();
      mpc = redirect_pc & 32'hFFFF_FFFC;
    end else begin
      m_pop  = (mq.size() > 0) && out_ready;
      m_push = (mq.size() < DEPTH) || m_pop;
      if (m_pop) void'(mq.pop_front());
      if (m_push) begin
        e.inst = imem[mpc[11:2]];
        e.pc4  = mpc + 32'd4;
        mpc    = model_next(mpc, e.inst, m_pred);
        e.pred = m_pred;
        mq.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("m_count", {29'd0, count}, mq.size());
      chk("m_valid", {31'd0, out_valid}, {31'd0, mq.size() != 0});
      chk("m_im_addr", {22'd0, im_addr}, {22'd0, mpc[11:2]});
      if (mq.size() != 0) begin
        chk("m_inst", out_inst, mq[0].inst);
        chk("m_pc4", out_pc4, mq[0].pc4);
        chk("m_pred", {31'd0, out_pred_taken}, {31'd0, mq[0].pred});
      end else begin
        chk("m_inst0", out_inst, 32'd0);
        chk("m_pc40", out_pc4, 32'd0);
        chk("m_pred0", {31'd0, out_pred_taken}, 32'd0);
      end
    end
  end

  task automatic rst_on();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_count", {29'd0, count}, 32'd0);
    chk("rst_async_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk("rst_inst", out_inst, 32'd0);
    chk("rst_pc4", out_pc4, 32'd0);
    chk("rst_pred", {31'd0, out_pred_taken}, 32'd0);
    chk("rst_im_addr", {22'd0, im_addr}, 32'd0);
  endtask

  task automatic rst_off();
    #2 rst = 1'b0;
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 1024; i++) imem[i] = 32'd0;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    int          k;
    r = $urandom;
    k = $urandom_range(0, 9);
    if (k == 0) return {6'd2, 26'h0000C00 + 26'($urandom_range(0, 1023))};
    if (k == 1) return {6'd3, 26'h0000C00 + 26'($urandom_range(0, 1023))};
    if (k == 2 || k == 3) begin
      if ($urandom_range(0, 1) == 1)
        return {(k == 2) ? 6'd4 : 6'd5, r[25:16], 16'hFFFF - 16'($urandom_range(0, 20))};
      return {(k == 2) ? 6'd4 : 6'd5, r[25:16], 16'($urandom_range(0, 20))};
    end
    return {6'd0, r[25:0]};
  endfunction

  initial begin
    clear_imem();

    // Sequential code after reset, decode always ready.
    rst_on();
    model_on = 1'b1;
    rst_off();
    out_ready = 1'b1;
    @(negedge clk);
    chk("t1_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_pc4_a", out_pc4, 32'h0000_3004);
    @(negedge clk);
    chk("t1_pc4_b", out_pc4, 32'h0000_3008);
    @(negedge clk);
    chk("t1_pc4_c", out_pc4, 32'h0000_300C);

    // Fill while stalled, then drain/refill across pointer wrap.
    out_ready = 1'b0;
    rst_on();
    rst_off();
    repeat (8) @(negedge clk);
    chk("t2_count_full", {29'd0, count}, 32'd4);
    chk("t2_im_addr_frozen", {22'd0, im_addr}, 32'h004);
    chk("t2_head", out_pc4, 32'h0000_3004);
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("t5_count", {29'd0, count}, 32'd4);
      chk("t5_pc4", out_pc4, 32'h0000_3008 + 32'(4 * i));
      chk("t5_im_addr", {22'd0, im_addr}, 32'(5 + i));
    end

    // J at 0x3000 jumps to 0x3004 and is still enqueued.
    out_ready = 1'b0;
    rst_on();
    imem[0] = 32'h0800_0C01;
    rst_off();
    @(negedge clk);
    chk("t3_count", {29'd0, count}, 32'd1);
    chk("t3_inst", out_inst, 32'h0800_0C01);
    chk("t3_pc4", out_pc4, 32'h0000_3004);
    chk("t3_next_fetch", {22'd0, im_addr}, 32'h001);
    @(negedge clk);
    chk("t3_count2", {29'd0, count}, 32'd2);
    chk("t3_im_addr2", {22'd0, im_addr}, 32'h002);

    // Redirect flushes a partially filled queue.
    rst_on();
    clear_imem();
    rst_off();
    repeat (3) @(negedge clk);
    chk("t4_count3", {29'd0, count}, 32'd3);
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_3043;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("t4_count0", {29'd0, count}, 32'd0);
    chk("t4_valid0", {31'd0, out_valid}, 32'd0);
    chk("t4_im_addr", {22'd0, im_addr}, 32'h010);
    @(negedge clk);
    chk("t4_valid1", {31'd0, out_valid}, 32'd1);
    chk("t4_pc4", out_pc4, 32'h0000_3044);

    // Backward BNE at 0x3010.
    rst_on();
    imem[4] = 32'h1400_FFFC;
    rst_off();
    repeat (5) @(negedge clk);
    chk("t6_inst", out_inst, 32'h1400_FFFC);
    chk("t6_pc4", out_pc4, 32'h0000_3014);
    chk("t6_pred", {31'd0, out_pred_taken}, BTFN ? 32'd1 : 32'd0);
    chk("t6_next_fetch", {22'd0, im_addr}, BTFN ? 32'h001 : 32'h005);
    @(negedge clk);
    chk("t6_after", out_pc4, BTFN ? 32'h0000_3008 : 32'h0000_3018);

    // Randomized traffic with jumps, branches, stalls and redirects.
    for (int phase = 0; phase < 3; phase++) begin
      rst_on();
      for (int i = 0; i < 1024; i++) imem[i] = rand_inst();
      rst_off();
      for (int c = 0; c < 1500; c++) begin
        @(negedge clk);
        case (phase)
          0:       out_ready = ($urandom_range(0, 3) != 0);
          1:       out_ready = ($urandom_range(0, 3) == 0);
          default: out_ready = ($urandom_range(0, 1) == 1);
        endcase
        redirect_valid = ($urandom_range(0, 19) == 0);
        redirect_pc    = 32'h0000_3000 + 32'($urandom_range(0, 1023) << 2)
                         + 32'($urandom_range(0, 3));
      end
      redirect_valid = 1'b0;
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
